div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider in the execute stage that produces the 64-bit value written into the HI/LO register pair for DIV/DIVU. It computes {remainder, quotient} with a radix-2 restoring algorithm, one quotient bit per cycle. It signals busy so the pipeline can stall, and pulses done for the single cycle in which the result is valid for the HI/LO write. A cancel input aborts the operation on pipeline flush or exception.

## Interface
Parameters:
- none (operand width fixed at 32, result width fixed at 64)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request a divide; sampled only in IDLE
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; latched with start
- a  input  32  dividend; latched with start
- b  input  32  divisor; latched with start
- cancel  input  1  synchronous abort (flush/exception); highest priority after rst
- busy  output  1  1 while an operation is in flight (BUSY state)
- done  output  1  one-cycle pulse; result valid this cycle
- result  output  64  {remainder[63:32], quotient[31:0]}; HI gets remainder, LO gets quotient

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if start && !cancel, latch a, b, is_signed; compute magnitudes |a|, |b| (if signed and operand negative, two's-complement negate); set quotient sign qs = a[31]^b[31], remainder sign rs = a[31] (signed only, else 0); clear 33-bit partial remainder; counter = 0; go to BUSY.
- BUSY: each cycle shift {partial_rem, dividend_mag} left by 1; trial = partial_rem[32:0] - {1'b0,|b|}; if trial non-negative, partial_rem = trial and shift in quotient bit 1, else shift in 0; counter++; after iteration 32 (counter == 31 at edge) go to DONE.
- DONE: result <= {rs ? -rem : rem, qs ? -quo : quo}; done = 1 for exactly this cycle; next state IDLE unconditionally. start in DONE is ignored.
- Arithmetic: all magnitude math unsigned; negation mod 2^32.
- Divide by zero (b == 0): no special path; restoring loop yields quotient 32'hFFFFFFFF and remainder |a|. Sign fix-up is still applied, so for signed with b = 0: quotient = qs ? 32'h00000001 : 32'hFFFFFFFF, remainder = a. Latency is unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This is natural from the magnitude method; no special case.
- start while BUSY or DONE: ignored, with no queuing. The issuing stage holds its instruction until it sees done.
- cancel: from any state, next state IDLE; no done is produced; result keeps its previous value. cancel && start in IDLE: cancel wins and nothing is latched.
- rst: state IDLE, busy 0, done 0, result 64'h0, counter 0, latched operands 0. Reset mid-operation discards the operation with no done.

## Timing
- Cycle 0: start high in IDLE (accepted at the edge ending cycle 0).
- Cycles 1..32: BUSY, busy = 1, done = 0.
- Cycle 33: DONE, done = 1, busy = 0, result valid (registered, stable from start of cycle).
- Cycle 34: IDLE; earliest new accept is start high in cycle 34.
- Latency start→done: 33 cycles. Throughput: one divide per 34 cycles.
- result holds its value from the DONE cycle until the next DONE or rst; it never changes on cancel.
- busy and done are registered and never high simultaneously.
- The HI/LO write enable is driven from done by the integrating logic, not inside this block.

## Test plan
- Unsigned basic: start, is_signed = 0, a = 100, b = 7 in cycle 0 → busy cycles 1–32, done in cycle 33 only, result = {32'd2, 32'd14}.
- Signed negatives: a = 0xFFFFFFF9 (−7), b = 2, is_signed = 1 → result = {32'hFFFFFFFF, 32'hFFFFFFFD} (r = −1, q = −3). Then a = 7, b = 0xFFFFFFFE → {32'h00000001, 32'hFFFFFFFD}.
- Boundary values: signed 0x80000000 / 0xFFFFFFFF → {32'h0, 32'h80000000}. Unsigned 5 / 0 → {32'h5, 32'hFFFFFFFF}. Unsigned 0xFFFFFFFF / 1 → {0, 32'hFFFFFFFF}, each at cycle 33.
- Cancel: start at cycle 0, cancel in cycle 10 → busy = 0 from cycle 11, no done through cycle 40, result unchanged. cancel && start together in IDLE → nothing starts.
- Handshake: start held high continuously → accepts in cycles 0 and 34 only. start pulses during BUSY and in the DONE cycle are ignored, confirmed by exactly two done pulses with correct results.
- Reset: rst in cycle 15 of an operation → next cycle busy = 0, done = 0, result = 0. A new start after reset completes normally in 33 cycles.

Source files
------------

// File: rtl/div_unit_if.sv
// ----------------------------------------------------------------------------
// div_unit_if
// Handshake/data bundle between the execute stage and the multi-cycle divider.
//   start      issuing stage -> divider : request a divide (sampled in IDLE)
//   is_signed  issuing stage -> divider : 1 = DIV, 0 = DIVU
//   a, b       issuing stage -> divider : dividend / divisor
//   cancel     issuing stage -> divider : abort on flush or exception
//   busy       divider -> issuing stage : operation in flight, stall
//   done       divider -> issuing stage : one-cycle pulse, result valid
//   result     divider -> issuing stage : {remainder, quotient} for HI/LO
// ----------------------------------------------------------------------------
interface div_unit_if;
   logic        start;
   logic        is_signed;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [63:0] result;

   modport master (
      output start, is_signed, a, b, cancel,
      input  busy, done, result
   );

   modport slave (
      input  start, is_signed, a, b, cancel,
      output busy, done, result
   );
endinterface

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU. Produces the
// 64-bit HI/LO value {remainder, quotient}, one quotient bit per cycle.
// Start-to-done latency is 33 cycles; one divide per 34 cycles.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous, active-high reset
//   div   div_unit_if.slave: start/is_signed/a/b/cancel in,
//         busy/done/result out (see div_unit_if.sv)
// ----------------------------------------------------------------------------
module div_unit (
   input  logic      clk,
   input  logic      rst,
   div_unit_if.slave div
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] part_rem;   // partial remainder (always < |b|, or |a| when b == 0)
   logic [31:0] dq;         // dividend magnitude shifting out, quotient shifting in
   logic [31:0] b_mag;
   logic        q_neg;
   logic        r_neg;
   logic [4:0]  count;
   logic        busy_q;
   logic        done_q;
   logic [63:0] result_q;

   // Operand magnitudes for the accept cycle.
   logic [31:0] a_mag_in;
   logic [31:0] b_mag_in;

   // One restoring iteration.
   logic [32:0] shifted;
   logic        trial_ok;
   logic [31:0] rem_next;
   logic [31:0] dq_next;
   logic [31:0] rem_fix;
   logic [31:0] quo_fix;

   assign a_mag_in = (div.is_signed && div.a[31]) ? (~div.a + 32'd1) : div.a;
   assign b_mag_in = (div.is_signed && div.b[31]) ? (~div.b + 32'd1) : div.b;

   // trial = shifted - {0,|b|} is non-negative exactly when shifted >= |b|;
   // the difference then fits in 32 bits because shifted < 2*|b|.
   assign shifted  = {part_rem, dq[31]};
   assign trial_ok = (shifted >= {1'b0, b_mag});
   assign rem_next = trial_ok ? (shifted[31:0] - b_mag) : shifted[31:0];
   assign dq_next  = {dq[30:0], trial_ok};

   // Sign fix-up of the final iteration's output, so result is already
   // registered at the start of the DONE cycle.
   assign rem_fix = r_neg ? (~rem_next + 32'd1) : rem_next;
   assign quo_fix = q_neg ? (~dq_next + 32'd1) : dq_next;

   // NOTE: every output of a combinational block gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (div.start) state_next = S_BUSY;
         S_BUSY:  if (count == 5'd31) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      // cancel overrides any transition, including an accept in IDLE.
      if (div.cancel) state_next = S_IDLE;
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         part_rem <= '0;
         dq       <= '0;
         b_mag    <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         count    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state  <= state_next;
         busy_q <= (state_next == S_BUSY);
         done_q <= (state_next == S_DONE);

         case (state)
            S_IDLE: begin
               if (div.start && !div.cancel) begin
                  dq       <= a_mag_in;
                  b_mag    <= b_mag_in;
                  part_rem <= '0;
                  count    <= '0;
                  q_neg    <= div.is_signed & (div.a[31] ^ div.b[31]);
                  r_neg    <= div.is_signed & div.a[31];
               end
            end
            S_BUSY: begin
               if (!div.cancel) begin
                  part_rem <= rem_next;
                  dq       <= dq_next;
                  count    <= count + 5'd1;
                  if (count == 5'd31) result_q <= {rem_fix, quo_fix};
               end
            end
            default: ;
         endcase
      end
   end

   assign div.busy   = busy_q;
   assign div.done   = done_q;
   assign div.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit
// Directed test of div_unit: reset state, unsigned/signed divides, boundary
// operands, cancel, start handshake and mid-operation reset. Cycle n below
// means the interval after the n-th rising edge following the start cycle.
// ----------------------------------------------------------------------------
module tb_div_unit;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   div_unit_if bus ();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .div (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one divide in cycle 0 and check timing and result through cycle 34.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp);
      int busy_cnt;
      int done_cnt;
      busy_cnt = 0;
      done_cnt = 0;
      bus.start     = 1'b1;
      bus.is_signed = sgn;
      bus.a         = av;
      bus.b         = bv;
      tick();
      bus.start = 1'b0;
      bus.a     = 32'hDEAD_BEEF;
      bus.b     = 32'h0000_0003;
      for (int c = 1; c <= 32; c++) begin
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.done !== 1'b0) done_cnt++;
         tick();
      end
      check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
      check({tag, " early_done"}, 64'(done_cnt), 64'd0);
      check({tag, " done@33"}, {62'd0, bus.busy, bus.done}, 64'd1);
      check({tag, " result"}, bus.result, exp);
      tick();
      check({tag, " idle@34"}, {62'd0, bus.busy, bus.done}, 64'd0);
   endtask

   initial begin
      logic [63:0] prev;
      int          done_cnt;
      n_cmp = 0;
      n_err = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cancel    = 1'b0;
      tick();
      tick();
      check("reset busy", {63'd0, bus.busy}, 64'd0);
      check("reset done", {63'd0, bus.done}, 64'd0);
      check("reset result", bus.result, 64'd0);
      rst = 1'b0;
      tick();

      // Basic and signed divides.
      run_div("u100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
      run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});

      // Boundary operands.
      run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
      run_div("u5/0", 1'b0, 32'd5, 32'd0, {32'h5, 32'hFFFF_FFFF});
      run_div("umax/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF});
      run_div("s-5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'h0000_0001});

      // Cancel in cycle 10: busy drops in cycle 11, no done through cycle 40.
      prev          = bus.result;
      done_cnt      = 0;
      bus.start     = 1'b1;
      bus.is_signed = 1'b0;
      bus.a         = 32'd1000;
      bus.b         = 32'd3;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
      check("cancel busy@11", {63'd0, bus.busy}, 64'd0);
      for (int c = 11; c <= 40; c++) begin
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_cnt++;
         tick();
      end
      check("cancel no_activity", 64'(done_cnt), 64'd0);
      check("cancel result_kept", bus.result, prev);

      // cancel together with start in IDLE: nothing is accepted.
      bus.start  = 1'b1;
      bus.cancel = 1'b1;
      bus.a      = 32'd9;
      bus.b      = 32'd2;
      tick();
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      check("cancel+start busy", {63'd0, bus.busy}, 64'd0);
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done !== 1'b0) done_cnt++;
         tick();
      end
      check("cancel+start no_done", 64'(done_cnt), 64'd0);
      check("cancel+start result", bus.result, prev);

      // start held high: accepts in cycles 0 and 34 only. Operands change
      // during BUSY to show they are not re-sampled.
      done_cnt      = 0;
      bus.start     = 1'b1;
      bus.is_signed = 1'b0;
      bus.a         = 32'd50;
      bus.b         = 32'd5;
      tick();
      for (int c = 1; c <= 70; c++) begin
         if (c == 1) begin
            bus.a = 32'd51;
            bus.b = 32'd5;
         end
         if (bus.done === 1'b1) done_cnt++;
         if (c == 33) check("hold result1", bus.result, {32'd1 - 32'd1, 32'd10});
         if (c == 34) check("hold idle@34", {62'd0, bus.busy, bus.done}, 64'd0);
         if (c == 35) check("hold busy@35", {63'd0, bus.busy}, 64'd1);
         if (c == 67) begin
            check("hold result2", bus.result, {32'd1, 32'd10});
            bus.start = 1'b0;
         end
         tick();
      end
      check("hold done_pulses", 64'(done_cnt), 64'd2);

      // Reset in cycle 15 of an operation.
      bus.start = 1'b1;
      bus.a     = 32'd77;
      bus.b     = 32'd4;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < 15; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst busy", {63'd0, bus.busy}, 64'd0);
      check("rst done", {63'd0, bus.done}, 64'd0);
      check("rst result", bus.result, 64'd0);
      run_div("post_rst 9/2", 1'b0, 32'd9, 32'd2, {32'd1, 32'd4});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
